teclado_escaner: RTL and testbench

Parametrised matrix-keypad scanner. Drives keypad columns one at a time, samples the rows through a 2-flop synchroniser and debounces both press and release. Emits exactly one registered key event per physical press, as a raw index plus a translated key code. It feeds the calculator input path that consumes 4-bit key codes.

---
 rtl/teclado_pkg.sv | 16 +
 rtl/teclado_mapa.sv | 16 +
 rtl/teclado_escaner.sv | 117 +++++++++++
 tb/tb_teclado_escaner.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/teclado_pkg.sv
// teclado_pkg: key codes, scanner FSM states and the telephone-layout key map
package teclado_pkg;
  localparam logic [3:0] TEC_A   = 4'hA;
  localparam logic [3:0] TEC_B   = 4'hB;
  localparam logic [3:0] TEC_C   = 4'hC;
  localparam logic [3:0] TEC_D   = 4'hD;
  localparam logic [3:0] TEC_AST = 4'hE;
  localparam logic [3:0] TEC_NUM = 4'hF;
  typedef enum logic [2:0] {SCAN, DEB_PRESS, EMIT, HOLD, DEB_REL} estado_t;
  function automatic logic [3:0] mapa_tel(input logic [3:0] i);
    logic [3:0] tabla [16];
    tabla = '{4'h1, 4'h2, 4'h3, TEC_A, 4'h4, 4'h5, 4'h6, TEC_B,
              4'h7, 4'h8, 4'h9, TEC_C, TEC_AST, 4'h0, TEC_NUM, TEC_D};
    return tabla[i];
  endfunction
endpackage

// File: rtl/teclado_mapa.sv
// teclado_mapa: combinational raw index to key code translation
module teclado_mapa
  import teclado_pkg::*;
#(
  parameter int IDX_W   = 4,
  parameter bit MAPA_EN = 1
) (
  input  logic [IDX_W-1:0] indice,
  output logic [IDX_W-1:0] codigo
);
  if (MAPA_EN) begin : g_mapa
    assign codigo = IDX_W'(mapa_tel(4'(indice)));
  end else begin : g_directo
    assign codigo = indice;
  end
endmodule

// File: rtl/teclado_escaner.sv
// teclado_escaner: matrix keypad scanner with synchronised, debounced press/release and one event per press
module teclado_escaner
  import teclado_pkg::*;
#(
  parameter int FILAS           = 4,
  parameter int COLUMNAS        = 4,
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter bit MAPA_EN         = 1,
  parameter int IDX_W           = $clog2(FILAS*COLUMNAS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [FILAS-1:0]    filas_n,
  output logic [COLUMNAS-1:0] columnas_n,
  output logic [IDX_W-1:0]    indice,
  output logic [IDX_W-1:0]    codigo,
  output logic                tecla_valida,
  output logic                tecla_presionada
);
  localparam int ROW_W = FILAS > 1 ? $clog2(FILAS) : 1;
  localparam int COL_W = COLUMNAS > 1 ? $clog2(COLUMNAS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
  if (MAPA_EN && (FILAS != 4 || COLUMNAS != 4)) begin : g_err
    $error("teclado_escaner: MAPA_EN=1 requires a 4x4 keypad");
  end
  estado_t estado, estado_n;
  logic [FILAS-1:0] s1, filas_s, patron, patron_n;
  logic [COL_W-1:0] col, col_n, col_sig;
  logic [DIV_W-1:0] cnt_div, cnt_div_n;
  logic [DEB_W-1:0] cnt_deb, cnt_deb_n;
  logic [ROW_W-1:0] fila_sel;
  logic [IDX_W-1:0] idx_lat, idx_n, codigo_map;
  logic libre, fin_div, fin_deb;
  assign libre   = &filas_s;
  assign fin_div = cnt_div == DIV_W'(SCAN_DIV-1);
  assign fin_deb = cnt_deb == DEB_W'(DEBOUNCE_CYCLES-1);
  assign col_sig = col == COL_W'(COLUMNAS-1) ? '0 : col + 1'b1;
  assign columnas_n = ~(COLUMNAS'(1) << col);
  teclado_mapa #(.IDX_W(IDX_W), .MAPA_EN(MAPA_EN)) u_mapa (.indice(idx_lat), .codigo(codigo_map));
  // lowest-index low row wins when several rows are pressed together
  always_comb begin
    fila_sel = '0;
    for (int i = FILAS-1; i >= 0; i--) if (!filas_s[i]) fila_sel = ROW_W'(i);
  end
  always_comb begin
    estado_n  = estado;
    col_n     = col;
    cnt_div_n = cnt_div;
    cnt_deb_n = cnt_deb;
    patron_n  = patron;
    idx_n     = idx_lat;
    case (estado)
      SCAN: begin
        cnt_div_n = fin_div ? '0 : cnt_div + 1'b1;
        if (fin_div && !libre) begin
          estado_n  = DEB_PRESS;
          patron_n  = filas_s;
          cnt_deb_n = '0;
          idx_n     = IDX_W'(fila_sel) * IDX_W'(COLUMNAS) + IDX_W'(col);
        end else if (fin_div) col_n = col_sig;
      end
      DEB_PRESS: begin
        if (filas_s != patron) begin
          estado_n = SCAN;
          col_n    = col_sig;
        end else if (fin_deb) estado_n = EMIT;
        else cnt_deb_n = cnt_deb + 1'b1;
      end
      EMIT: estado_n = HOLD;
      HOLD: begin
        estado_n  = libre ? DEB_REL : HOLD;
        cnt_deb_n = '0;
      end
      DEB_REL: begin
        if (!libre) cnt_deb_n = '0;
        else if (fin_deb) begin
          estado_n = SCAN;
          col_n    = col_sig;
        end else cnt_deb_n = cnt_deb + 1'b1;
      end
      default: estado_n = SCAN;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1               <= '1;
      filas_s          <= '1;
      estado           <= SCAN;
      col              <= '0;
      cnt_div          <= '0;
      cnt_deb          <= '0;
      patron           <= '1;
      idx_lat          <= '0;
      indice           <= '0;
      codigo           <= '0;
      tecla_valida     <= 1'b0;
      tecla_presionada <= 1'b0;
    end else begin
      s1               <= filas_n;
      filas_s          <= s1;
      estado           <= estado_n;
      col              <= col_n;
      cnt_div          <= cnt_div_n;
      cnt_deb          <= cnt_deb_n;
      patron           <= patron_n;
      idx_lat          <= idx_n;
      tecla_valida     <= estado_n == EMIT;
      tecla_presionada <= estado_n inside {EMIT, HOLD, DEB_REL};
      if (estado_n == EMIT) begin
        indice <= idx_lat;
        codigo <= codigo_map;
      end
    end
  end
endmodule

// File: tb/tb_teclado_escaner.sv
// tb_teclado_escaner: directed checks of scanning, debouncing, key map and reset behaviour
module tb_teclado_escaner;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] filas_n, columnas_n, indice, codigo;
  logic       tecla_valida, tecla_presionada;
  logic [15:0] tecla = '0;
  int asserts = 0;
  int fails = 0;
  int pulsos = 0;

  teclado_escaner #(.FILAS(4), .COLUMNAS(4), .SCAN_DIV(4), .DEBOUNCE_CYCLES(8), .MAPA_EN(1)) dut (
    .clk(clk), .rst(rst), .filas_n(filas_n), .columnas_n(columnas_n), .indice(indice),
    .codigo(codigo), .tecla_valida(tecla_valida), .tecla_presionada(tecla_presionada));

  always #5 clk = ~clk;

  always_comb begin
    filas_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (tecla[r*4+c] && !columnas_n[c]) filas_n[r] = 1'b0;
  end

  always @(negedge clk) if (tecla_valida === 1'b1) pulsos++;

  task automatic ciclos(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic esperar_valida(input int limite, output bit ok, output logic [3:0] idx, output logic [3:0] cod);
    ok = 1'b0;
    idx = 'x;
    cod = 'x;
    for (int i = 0; i < limite && !ok; i++) begin
      @(negedge clk);
      if (tecla_valida === 1'b1) begin
        ok = 1'b1;
        idx = indice;
        cod = codigo;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tecla = '0;
    ciclos(3);
    asserts++; if (columnas_n !== 4'b1110) begin fails++; $display("FAIL reset_columnas got %b exp 1110", columnas_n); end
    asserts++; if (indice !== 4'd0) begin fails++; $display("FAIL reset_indice got %h exp 0", indice); end
    asserts++; if (codigo !== 4'd0) begin fails++; $display("FAIL reset_codigo got %h exp 0", codigo); end
    asserts++; if (tecla_valida !== 1'b0) begin fails++; $display("FAIL reset_valida got %b exp 0", tecla_valida); end
    asserts++; if (tecla_presionada !== 1'b0) begin fails++; $display("FAIL reset_presionada got %b exp 0", tecla_presionada); end
  endtask

  task automatic test_barrido;
    int base;
    logic [3:0] esp;
    base = pulsos;
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      esp = ~(4'b0001 << ((k / 4) % 4));
      asserts++; if (columnas_n !== esp) begin fails++; $display("FAIL barrido_col k=%0d got %b exp %b", k, columnas_n, esp); end
      @(negedge clk);
    end
    asserts++; if (pulsos !== base) begin fails++; $display("FAIL barrido_sin_evento got %0d exp %0d", pulsos - base, 0); end
  endtask

  task automatic test_tecla_limpia;
    int base;
    bit ok;
    logic [3:0] idx, cod;
    base = pulsos;
    tecla = 16'h1 << (1*4+2);
    esperar_valida(200, ok, idx, cod);
    asserts++; if (!ok) begin fails++; $display("FAIL limpia_timeout got none exp pulse"); end
    asserts++; if (idx !== 4'd6) begin fails++; $display("FAIL limpia_indice got %h exp 6", idx); end
    asserts++; if (cod !== 4'b0110) begin fails++; $display("FAIL limpia_codigo got %b exp 0110", cod); end
    ciclos(30);
    asserts++; if (pulsos !== base + 1) begin fails++; $display("FAIL limpia_pulsos got %0d exp 1", pulsos - base); end
    asserts++; if (tecla_presionada !== 1'b1) begin fails++; $display("FAIL limpia_presionada got %b exp 1", tecla_presionada); end
    asserts++; if (indice !== 4'd6) begin fails++; $display("FAIL limpia_indice_held got %h exp 6", indice); end
    tecla = '0;
    ciclos(9);
    asserts++; if (tecla_presionada !== 1'b1) begin fails++; $display("FAIL limpia_pres_deb got %b exp 1", tecla_presionada); end
    ciclos(4);
    asserts++; if (tecla_presionada !== 1'b0) begin fails++; $display("FAIL limpia_soltada got %b exp 0", tecla_presionada); end
    ciclos(10);
  endtask

  task automatic test_rebote_pulsar;
    int base;
    bit ok;
    logic [3:0] idx, cod;
    base = pulsos;
    for (int i = 0; i < 20; i++) begin
      tecla = ((i / 3) % 2 == 0) ? 16'h0001 : 16'h0000;
      @(negedge clk);
    end
    asserts++; if (pulsos !== base) begin fails++; $display("FAIL rebote_sin_evento got %0d exp 0", pulsos - base); end
    tecla = 16'h0001;
    esperar_valida(200, ok, idx, cod);
    asserts++; if (!ok) begin fails++; $display("FAIL rebote_timeout got none exp pulse"); end
    asserts++; if (idx !== 4'd0) begin fails++; $display("FAIL rebote_indice got %h exp 0", idx); end
    asserts++; if (cod !== 4'd1) begin fails++; $display("FAIL rebote_codigo got %h exp 1", cod); end
    ciclos(20);
    tecla = '0;
    ciclos(20);
    asserts++; if (pulsos !== base + 1) begin fails++; $display("FAIL rebote_pulsos got %0d exp 1", pulsos - base); end
  endtask

  task automatic test_rebote_soltar;
    int base;
    bit ok;
    logic [3:0] idx, cod;
    base = pulsos;
    tecla = 16'h1 << (2*4+3);
    esperar_valida(200, ok, idx, cod);
    asserts++; if (!ok) begin fails++; $display("FAIL soltar_timeout got none exp pulse"); end
    asserts++; if (cod !== 4'hC) begin fails++; $display("FAIL soltar_codigo got %h exp C", cod); end
    ciclos(10);
    for (int i = 0; i < 15; i++) begin
      tecla = ((i / 2) % 2 == 1) ? 16'h1 << (2*4+3) : 16'h0;
      @(negedge clk);
    end
    tecla = '0;
    ciclos(5);
    asserts++; if (tecla_presionada !== 1'b1) begin fails++; $display("FAIL soltar_pres_deb got %b exp 1", tecla_presionada); end
    ciclos(8);
    asserts++; if (tecla_presionada !== 1'b0) begin fails++; $display("FAIL soltar_soltada got %b exp 0", tecla_presionada); end
    asserts++; if (pulsos !== base + 1) begin fails++; $display("FAIL soltar_pulsos got %0d exp 1", pulsos - base); end
    ciclos(10);
  endtask

  task automatic test_secuencia;
    logic [15:0] mascara [3];
    logic [3:0]  exp_idx [3];
    logic [3:0]  exp_cod [3];
    bit ok;
    logic [3:0] idx, cod;
    mascara = '{16'h1 << 12, 16'h1 << 13, (16'h1 << 3) | (16'h1 << 11)};
    exp_idx = '{4'd12, 4'd13, 4'd3};
    exp_cod = '{4'b1110, 4'b0000, 4'b1010};
    for (int t = 0; t < 3; t++) begin
      tecla = mascara[t];
      esperar_valida(200, ok, idx, cod);
      asserts++; if (!ok) begin fails++; $display("FAIL sec_timeout t=%0d got none exp pulse", t); end
      asserts++; if (idx !== exp_idx[t]) begin fails++; $display("FAIL sec_indice t=%0d got %h exp %h", t, idx, exp_idx[t]); end
      asserts++; if (cod !== exp_cod[t]) begin fails++; $display("FAIL sec_codigo t=%0d got %b exp %b", t, cod, exp_cod[t]); end
      ciclos(30);
      tecla = '0;
      ciclos(20);
      asserts++; if (tecla_presionada !== 1'b0) begin fails++; $display("FAIL sec_soltada t=%0d got %b exp 0", t, tecla_presionada); end
    end
  endtask

  task automatic test_reset_medio;
    int base;
    bit ok;
    logic [3:0] idx, cod;
    rst = 1'b1;
    tecla = 16'h1 << (1*4+1);
    ciclos(2);
    rst = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = columnas_n == 4'b1101;
    end
    ciclos(6);
    base = pulsos;
    rst = 1'b1;
    #1;
    asserts++; if (columnas_n !== 4'b1110) begin fails++; $display("FAIL rstdeb_columnas got %b exp 1110", columnas_n); end
    asserts++; if (indice !== 4'd0) begin fails++; $display("FAIL rstdeb_indice got %h exp 0", indice); end
    asserts++; if (tecla_presionada !== 1'b0) begin fails++; $display("FAIL rstdeb_presionada got %b exp 0", tecla_presionada); end
    tecla = '0;
    ciclos(2);
    rst = 1'b0;
    ciclos(40);
    asserts++; if (pulsos !== base) begin fails++; $display("FAIL rstdeb_sin_evento got %0d exp 0", pulsos - base); end
    tecla = 16'h1 << (1*4+1);
    esperar_valida(200, ok, idx, cod);
    asserts++; if (cod !== 4'd5) begin fails++; $display("FAIL rsthold_codigo got %h exp 5", cod); end
    ciclos(5);
    base = pulsos;
    rst = 1'b1;
    #1;
    asserts++; if (tecla_presionada !== 1'b0) begin fails++; $display("FAIL rsthold_presionada got %b exp 0", tecla_presionada); end
    asserts++; if (indice !== 4'd0) begin fails++; $display("FAIL rsthold_indice got %h exp 0", indice); end
    asserts++; if (codigo !== 4'd0) begin fails++; $display("FAIL rsthold_codigo0 got %h exp 0", codigo); end
    tecla = '0;
    ciclos(2);
    rst = 1'b0;
    ciclos(40);
    asserts++; if (pulsos !== base) begin fails++; $display("FAIL rsthold_sin_evento got %0d exp 0", pulsos - base); end
  endtask

  initial begin
    test_reset;
    test_barrido;
    test_tecla_limpia;
    test_rebote_pulsar;
    test_rebote_soltar;
    test_secuencia;
    test_reset_medio;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
